// File: rtl/ccu_pkg.sv
// Shared types for the snoop fan-out: CR bit positions, FSM states and default
// snoop port structs (AC request, CR response, CD data beat).
package ccu_pkg;

  localparam int unsigned CR_DT  = 0;
  localparam int unsigned CR_ERR = 1;
  localparam int unsigned CR_PD  = 2;
  localparam int unsigned CR_IS  = 3;
  localparam int unsigned CR_WU  = 4;
  localparam int unsigned CR_W   = 5;

  typedef enum logic [2:0] {IDLE, AC_SEND, CR_WAIT, RESP, CD} fanout_state_e;

  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic            ac_ready;
    logic [CR_W-1:0] cr;
    logic            cr_valid;
    cd_chan_t        cd;
    logic            cd_valid;
  } snoop_resp_t;

endpackage

// File: rtl/ccu_cr_merge.sv
// Folds this cycle's accepted CRs into the running merge and picks the CD
// source: lowest PassDirty master first, else lowest DataTransfer master.
module ccu_cr_merge
  import ccu_pkg::*;
#(
  parameter int unsigned NoMst = 4,
  parameter int unsigned IdxW  = $clog2(NoMst)
)(
  input  logic [NoMst-1:0][CR_W-1:0] cr_i,
  input  logic [NoMst-1:0]           hs_i,
  input  logic [CR_W-1:0]            merged_i,
  input  logic [NoMst-1:0]           dt_i,
  input  logic [NoMst-1:0]           pd_i,
  output logic [CR_W-1:0]            merged_o,
  output logic [NoMst-1:0]           dt_o,
  output logic [NoMst-1:0]           pd_o,
  output logic [IdxW-1:0]            src_o,
  output logic                       src_vld_o
);

  always_comb begin
    merged_o = merged_i;
    dt_o     = dt_i;
    pd_o     = pd_i;
    for (int i = 0; i < NoMst; i++) begin
      if (hs_i[i]) begin
        merged_o = merged_o | cr_i[i];
        if (cr_i[i][CR_DT]) dt_o[i] = 1'b1;
        if (cr_i[i][CR_PD]) pd_o[i] = 1'b1;
      end
    end
  end

  // Descending scans so the lowest index wins; the PD scan overrides DT.
  always_comb begin
    src_o     = '0;
    src_vld_o = 1'b0;
    for (int i = NoMst - 1; i >= 0; i--) begin
      if (dt_o[i]) begin
        src_o     = IdxW'(i);
        src_vld_o = 1'b1;
      end
    end
    for (int i = NoMst - 1; i >= 0; i--) begin
      if (pd_o[i]) begin
        src_o     = IdxW'(i);
        src_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccu_snoop_fanout.sv
// Broadcasts one upstream AC to the masked masters, merges their CRs into one
// upstream CR, forwards the selected master's CD line and drains the rest.
module ccu_snoop_fanout
  import ccu_pkg::*;
#(
  parameter int unsigned NoMst     = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CdBeats   = 8,
  parameter type snoop_req_t   = ccu_pkg::snoop_req_t,
  parameter type snoop_resp_t  = ccu_pkg::snoop_resp_t,
  parameter type domain_mask_t = logic [NoMst-1:0]
)(
  input  logic         clk_i,
  input  logic         rst_i,
  input  snoop_req_t   slv_snoop_req_i,
  output snoop_resp_t  slv_snoop_resp_o,
  input  domain_mask_t slv_mask_i,
  output snoop_req_t   mst_snoop_reqs_o [NoMst],
  input  snoop_resp_t  mst_snoop_resps_i [NoMst],
  output logic         busy_o
);

  localparam int unsigned IdxW = $clog2(NoMst);

  fanout_state_e             state_q, state_d;
  snoop_req_t                ac_req_q;
  logic [NoMst-1:0]          ac_pend_q, cr_pend_q, dt_q, pd_q, dt_nx, pd_nx;
  logic [NoMst-1:0]          ac_hs, cr_hs, cd_last_hs;
  logic [NoMst-1:0][CR_W-1:0] cr_vec;
  logic [CR_W-1:0]           merged_q, merged_nx;
  logic [IdxW-1:0]           src_q, src_nx;
  logic                      src_vld;
  logic [3:0]                beat_q;
  logic                      slv_ac_hs, slv_cr_hs, slv_cd_hs;

  assign busy_o    = (state_q != IDLE);
  assign slv_ac_hs = (state_q == IDLE) & slv_snoop_req_i.ac_valid;
  assign slv_cr_hs = (state_q == RESP) & slv_snoop_req_i.cr_ready;
  assign slv_cd_hs = slv_snoop_resp_o.cd_valid & slv_snoop_req_i.cd_ready;

  // ac_ready is masked by reset so every handshake signal is quiet in reset.
  always_comb begin
    slv_snoop_resp_o          = '0;
    slv_snoop_resp_o.ac_ready = (state_q == IDLE) & ~rst_i;
    slv_snoop_resp_o.cr_valid = (state_q == RESP);
    slv_snoop_resp_o.cr       = merged_q;
    slv_snoop_resp_o.cd       = mst_snoop_resps_i[src_q].cd;
    slv_snoop_resp_o.cd_valid = (state_q == CD) & dt_q[src_q] & mst_snoop_resps_i[src_q].cd_valid;
    for (int i = 0; i < NoMst; i++) begin
      mst_snoop_reqs_o[i]          = ac_req_q;
      mst_snoop_reqs_o[i].ac_valid = (state_q == AC_SEND) & ac_pend_q[i];
      mst_snoop_reqs_o[i].cr_ready = ((state_q == AC_SEND) | (state_q == CR_WAIT)) &
                                     cr_pend_q[i] & ~ac_pend_q[i];
      mst_snoop_reqs_o[i].cd_ready = (state_q == CD) & dt_q[i] &
                                     ((IdxW'(i) == src_q) ? slv_snoop_req_i.cd_ready : 1'b1);
    end
  end

  always_comb begin
    ac_hs      = '0;
    cr_hs      = '0;
    cd_last_hs = '0;
    cr_vec     = '0;
    for (int i = 0; i < NoMst; i++) begin
      ac_hs[i]      = mst_snoop_reqs_o[i].ac_valid & mst_snoop_resps_i[i].ac_ready;
      cr_hs[i]      = mst_snoop_reqs_o[i].cr_ready & mst_snoop_resps_i[i].cr_valid;
      cr_vec[i]     = mst_snoop_resps_i[i].cr;
      cd_last_hs[i] = mst_snoop_reqs_o[i].cd_ready & mst_snoop_resps_i[i].cd_valid &
                      mst_snoop_resps_i[i].cd.last;
    end
  end

  ccu_cr_merge #(.NoMst(NoMst), .IdxW(IdxW)) u_cr_merge (
    .cr_i      (cr_vec),
    .hs_i      (cr_hs),
    .merged_i  (merged_q),
    .dt_i      (dt_q),
    .pd_i      (pd_q),
    .merged_o  (merged_nx),
    .dt_o      (dt_nx),
    .pd_o      (pd_nx),
    .src_o     (src_nx),
    .src_vld_o (src_vld)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (slv_ac_hs) state_d = (slv_mask_i == '0) ? RESP : AC_SEND;
      AC_SEND: if ((ac_pend_q & ~ac_hs) == '0) state_d = CR_WAIT;
      CR_WAIT: if ((cr_pend_q & ~cr_hs) == '0) state_d = RESP;
      RESP:    if (slv_cr_hs) state_d = (dt_q == '0) ? IDLE : CD;
      CD:      if ((dt_q & ~cd_last_hs) == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ac_req_q  <= '0;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      merged_q  <= '0;
      dt_q      <= '0;
      pd_q      <= '0;
      src_q     <= '0;
      beat_q    <= '0;
    end else begin
      state_q <= state_d;
      if (slv_ac_hs) begin
        ac_req_q  <= slv_snoop_req_i;
        ac_pend_q <= slv_mask_i;
        cr_pend_q <= slv_mask_i;
        merged_q  <= '0;
        dt_q      <= '0;
        pd_q      <= '0;
      end else begin
        ac_pend_q <= ac_pend_q & ~ac_hs;
        cr_pend_q <= cr_pend_q & ~cr_hs;
        merged_q  <= merged_nx;
        dt_q      <= dt_nx & ~cd_last_hs;
        pd_q      <= pd_nx;
      end
      if ((state_q == CR_WAIT) && (state_d == RESP) && src_vld) src_q <= src_nx;
      if (slv_cr_hs) beat_q <= '0;
      else if (slv_cd_hs) beat_q <= slv_snoop_resp_o.cd.last ? 4'd0 : beat_q + 4'd1;
    end
  end

`ifndef SYNTHESIS
  localparam int unsigned AcAddrBits = $bits(ac_req_q.ac.addr);
  localparam int unsigned CdDataBits = $bits(slv_snoop_resp_o.cd.data);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (AcAddrBits == AddrWidth && CdDataBits == DataWidth) else $error("width mismatch");
      if (slv_cd_hs)
        assert (slv_snoop_resp_o.cd.last == (beat_q == 4'(CdBeats - 1))) else $error("last mismatch");
    end
  end
`endif

endmodule
